// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding unit: ALU operand source selects
// and the multi-cycle tracker state.
package hazard_forward_unit_pkg;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_BUSY = 2'b01,
    MC_DONE = 2'b10
  } mc_state_e;

endpackage

// File: rtl/hazard_forward_unit_mc_tracker.sv
// Tracks a multi-cycle (mul/div) op occupying EX: occupancy FSM, residency
// counter, latched destination register and a sticky overrun flag.
module mc_tracker
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mc_start,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  output logic [REG_ADDR_W-1:0] mc_rd,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic                  mc_overrun
);

  localparam int CNT_W = $clog2(MC_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LATENCY - 2);

  mc_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MC_IDLE;
    else     state <= state_nxt;
  end

  // BUSY holds for CNT_LOAD+1 cycles, i.e. MC_LATENCY-1; a new start in BUSY is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      MC_IDLE: if (mc_start) state_nxt = MC_BUSY;
      MC_BUSY: if (cnt == '0) state_nxt = MC_DONE;
      MC_DONE: state_nxt = mc_start ? MC_BUSY : MC_IDLE;
      default: state_nxt = MC_IDLE;
    endcase
  end

  always_comb begin
    mc_busy = (state == MC_BUSY);
    mc_done = (state == MC_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      mc_rd      <= '0;
      mc_overrun <= 1'b0;
    end else begin
      if (state != MC_BUSY && mc_start) begin
        cnt   <= CNT_LOAD;
        mc_rd <= idex_rd;
      end else if (state == MC_BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == MC_BUSY && mc_start) mc_overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use and multi-cycle
// dependency stalls, and branch flush of IF/ID.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic [REG_ADDR_W-1:0] idex_rs,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_wr,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_wr,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_wr,
  input  logic                  mc_start,
  input  logic                  branch_taken,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush_ifid,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic                  mc_overrun
);

  logic [REG_ADDR_W-1:0] mc_rd;
  logic                  load_use, mc_hazard;

  // The younger producer (EX/MEM) wins over MEM/WB; r0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] em_rd,
    input logic                  em_wr,
    input logic [REG_ADDR_W-1:0] mw_rd,
    input logic                  mw_wr
  );
    if (em_wr && em_rd != '0 && em_rd == src)      return FWD_EXMEM;
    else if (mw_wr && mw_rd != '0 && mw_rd == src) return FWD_MEMWB;
    else                                           return FWD_NONE;
  endfunction

  mc_tracker #(
    .REG_ADDR_W (REG_ADDR_W),
    .MC_LATENCY (MC_LATENCY)
  ) u_mc (
    .clk        (clk),
    .rst        (rst),
    .mc_start   (mc_start),
    .idex_rd    (idex_rd),
    .mc_rd      (mc_rd),
    .mc_busy    (mc_busy),
    .mc_done    (mc_done),
    .mc_overrun (mc_overrun)
  );

  always_comb begin
    fwd_a = fwd_sel(idex_rs, exmem_rd, exmem_wr, memwb_rd, memwb_wr);
    fwd_b = fwd_sel(idex_rt, exmem_rd, exmem_wr, memwb_rd, memwb_wr);
  end

  // A taken branch squashes IF/ID, so holding it would be pointless; the
  // bubble is still needed to keep the stalled consumer out of EX.
  always_comb begin
    load_use   = idex_memread && idex_wr && idex_rd != '0 &&
                 (idex_rd == ifid_rs || idex_rd == ifid_rt);
    mc_hazard  = mc_busy && mc_rd != '0 &&
                 (mc_rd == ifid_rs || mc_rd == ifid_rt);
    bubble     = load_use || mc_hazard;
    stall      = bubble && !branch_taken;
    flush_ifid = branch_taken;
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: combinational vector table plus
// cycle sequences for the multi-cycle tracker, checked through a scoreboard.
module tb_hazard_forward_unit;

  logic       clk, rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;
  logic       idex_wr, idex_memread, exmem_wr, memwb_wr, mc_start, branch_taken;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, bubble, flush_ifid, mc_busy, mc_done, mc_overrun;

  int total = 0;
  int bad   = 0;

  hazard_forward_unit #(.REG_ADDR_W(5), .MC_LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_wr(idex_wr), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_wr(exmem_wr),
    .memwb_rd(memwb_rd), .memwb_wr(memwb_wr),
    .mc_start(mc_start), .branch_taken(branch_taken),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .bubble(bubble),
    .flush_ifid(flush_ifid), .mc_busy(mc_busy), .mc_done(mc_done),
    .mc_overrun(mc_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // {fwd_a, fwd_b, stall, bubble, flush_ifid, mc_busy, mc_done, mc_overrun}
  typedef struct {
    string      name;
    logic [9:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    string      name;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd;
    logic       idex_wr, idex_memread;
    logic [4:0] exmem_rd;
    logic       exmem_wr;
    logic [4:0] memwb_rd;
    logic       memwb_wr, branch_taken;
    logic [1:0] fa, fb;
    logic       st, bu, fl;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [9:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic st, input logic bu, input logic fl,
                                    input logic busy, input logic done, input logic ovr);
    return {fa, fb, st, bu, fl, busy, done, ovr};
  endfunction

  task automatic expect_out(input string name, input logic [9:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic check_out();
    sb_t        e;
    logic [9:0] act;
    act = {fwd_a, fwd_b, stall, bubble, flush_ifid, mc_busy, mc_done, mc_overrun};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got %b with nothing expected", act);
      return;
    end
    e = sb.pop_front();
    if (act !== e.exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (fa fb st bu fl busy done ovr)", e.name, act, e.exp);
    end
  endtask

  task automatic idle_inputs();
    ifid_rs = 0; ifid_rt = 0; idex_rs = 0; idex_rt = 0; idex_rd = 0;
    idex_wr = 0; idex_memread = 0; exmem_rd = 0; exmem_wr = 0;
    memwb_rd = 0; memwb_wr = 0; mc_start = 0; branch_taken = 0;
  endtask

  task automatic add_vec(input string n,
                         input logic [4:0] frs, input logic [4:0] frt,
                         input logic [4:0] xrs, input logic [4:0] xrt, input logic [4:0] xrd,
                         input logic xwr, input logic xmr,
                         input logic [4:0] emrd, input logic emwr,
                         input logic [4:0] mwrd, input logic mwwr, input logic br,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic st, input logic bu, input logic fl);
    vec_t v;
    v.name = n; v.ifid_rs = frs; v.ifid_rt = frt; v.idex_rs = xrs; v.idex_rt = xrt;
    v.idex_rd = xrd; v.idex_wr = xwr; v.idex_memread = xmr; v.exmem_rd = emrd;
    v.exmem_wr = emwr; v.memwb_rd = mwrd; v.memwb_wr = mwwr; v.branch_taken = br;
    v.fa = fa; v.fb = fb; v.st = st; v.bu = bu; v.fl = fl;
    vecs.push_back(v);
  endtask

  // One cycle of a multi-cycle sequence: drive at negedge, check 2 units later.
  task automatic mc_cycle(input string n, input logic start, input logic [4:0] rd,
                          input logic [4:0] frs, input logic [4:0] frt,
                          input logic [9:0] exp);
    @(negedge clk);
    idle_inputs();
    mc_start = start; idex_rd = rd; ifid_rs = frs; ifid_rt = frt;
    expect_out(n, exp);
    #2;
    check_out();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    //      name           frs frt xrs xrt xrd wr mr emrd emwr mwrd mwwr br   fa     fb   st bu fl
    add_vec("all_zero",      0,  0,  0,  0,  0, 0, 0,  0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("fwd_a_exmem",   0,  0,  3,  0,  0, 0, 0,  3,  1,  3,  1, 0, 2'b10, 2'b00, 0, 0, 0);
    add_vec("fwd_a_memwb",   0,  0,  3,  0,  0, 0, 0,  3,  0,  3,  1, 0, 2'b01, 2'b00, 0, 0, 0);
    add_vec("fwd_a_rd0",     0,  0,  3,  0,  0, 0, 0,  0,  1,  0,  1, 0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("fwd_r0_src",    0,  0,  0,  0,  0, 0, 0,  0,  1,  0,  1, 0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("fwd_both_em",   0,  0,  4,  4,  0, 0, 0,  4,  1,  4,  1, 0, 2'b10, 2'b10, 0, 0, 0);
    add_vec("fwd_split",     0,  0,  2,  6,  0, 0, 0,  2,  1,  6,  1, 0, 2'b10, 2'b01, 0, 0, 0);
    add_vec("fwd_b_memwb_nw",0,  0,  0, 12,  0, 0, 0, 12,  0, 12,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("load_use_rt",   0,  5,  0,  0,  5, 1, 1,  0,  0,  0,  0, 0, 2'b00, 2'b00, 1, 1, 0);
    add_vec("load_use_rd0",  0,  0,  0,  0,  0, 1, 1,  0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("load_use_rs",  17,  0,  0,  0, 17, 1, 1,  0,  0,  0,  0, 0, 2'b00, 2'b00, 1, 1, 0);
    add_vec("load_no_wr",    0,  5,  0,  0,  5, 0, 1,  0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("no_load",       0,  5,  0,  0,  5, 1, 0,  0,  0,  0,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    add_vec("load_use_br",   0,  5,  0,  0,  5, 1, 1,  0,  0,  0,  0, 1, 2'b00, 2'b00, 0, 1, 1);
    add_vec("branch_only",   0,  0,  0,  0,  0, 0, 0,  0,  0,  0,  0, 1, 2'b00, 2'b00, 0, 0, 1);

    // Reset state, and hazard logic live while reset is held.
    #2;
    expect_out("reset_state", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
    check_out();
    idex_memread = 1; idex_wr = 1; idex_rd = 5; ifid_rt = 5;
    exmem_wr = 1; exmem_rd = 9; idex_rs = 9;
    #1;
    expect_out("reset_comb_live", mk(2'b10, 2'b00, 1, 1, 0, 0, 0, 0));
    check_out();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      ifid_rs = vecs[i].ifid_rs; ifid_rt = vecs[i].ifid_rt;
      idex_rs = vecs[i].idex_rs; idex_rt = vecs[i].idex_rt; idex_rd = vecs[i].idex_rd;
      idex_wr = vecs[i].idex_wr; idex_memread = vecs[i].idex_memread;
      exmem_rd = vecs[i].exmem_rd; exmem_wr = vecs[i].exmem_wr;
      memwb_rd = vecs[i].memwb_rd; memwb_wr = vecs[i].memwb_wr;
      branch_taken = vecs[i].branch_taken; mc_start = 0;
      expect_out(vecs[i].name, mk(vecs[i].fa, vecs[i].fb, vecs[i].st, vecs[i].bu,
                                  vecs[i].fl, 0, 0, 0));
      #1;
      check_out();
    end

    // Multi-cycle op, latency 4: BUSY cycles 1..3, DONE cycle 4, IDLE cycle 5.
    mc_cycle("mc_c0",      1, 7, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    mc_cycle("mc_c1_stall", 0, 0, 7, 0, mk(0, 0, 1, 1, 0, 1, 0, 0));
    mc_cycle("mc_c2_stall", 0, 0, 7, 0, mk(0, 0, 1, 1, 0, 1, 0, 0));
    mc_cycle("mc_c3_stall", 0, 0, 7, 0, mk(0, 0, 1, 1, 0, 1, 0, 0));
    mc_cycle("mc_c4_done",  0, 0, 7, 0, mk(0, 0, 0, 0, 0, 0, 1, 0));
    mc_cycle("mc_c5_idle",  0, 0, 7, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Overrun: a start in BUSY is ignored (mc_rd kept, count unchanged) and sticks.
    mc_cycle("ovr_c0",      1,  9,  0,  0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    mc_cycle("ovr_c1",      0,  0,  0,  0, mk(0, 0, 0, 0, 0, 1, 0, 0));
    mc_cycle("ovr_c2",      1, 10,  0, 10, mk(0, 0, 0, 0, 0, 1, 0, 0));
    mc_cycle("ovr_c3_keep", 0,  0,  0,  9, mk(0, 0, 1, 1, 0, 1, 0, 1));
    mc_cycle("ovr_c4_done", 0,  0,  0,  0, mk(0, 0, 0, 0, 0, 0, 1, 1));
    mc_cycle("ovr_c5",      0,  0,  0,  0, mk(0, 0, 0, 0, 0, 0, 0, 1));
    mc_cycle("ovr_c6_hold", 0,  0,  0,  0, mk(0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    expect_out("ovr_cleared_by_rst", mk(0, 0, 0, 0, 0, 0, 0, 0));
    check_out();
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted in cycle 2 of BUSY clears it asynchronously; no DONE follows.
    mc_cycle("rst_c0",  1, 7, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    mc_cycle("rst_c1",  0, 0, 7, 0, mk(0, 0, 1, 1, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    ifid_rs = 7;
    rst = 1'b1;
    #1;
    expect_out("rst_async_busy0", mk(0, 0, 0, 0, 0, 0, 0, 0));
    check_out();
    idex_memread = 1; idex_wr = 1; idex_rd = 5; ifid_rt = 5; branch_taken = 1;
    #1;
    expect_out("rst_load_use_br", mk(0, 0, 0, 1, 1, 0, 0, 0));
    check_out();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    mc_cycle("rst_post1", 0, 0, 7, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    mc_cycle("rst_post2", 0, 0, 7, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    // Full count after reset; r0 destination never creates a dependency.
    mc_cycle("re_c0",      1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    mc_cycle("re_c1_r0",   0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0));
    mc_cycle("re_c2_r0",   0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0));
    mc_cycle("re_c3_r0",   0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 0, 0));
    mc_cycle("re_c4_done", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 0));
    mc_cycle("re_c5_idle", 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
